// File: rtl/slib_hyst_filter.sv
// Multi-channel debounce filter: a saturating integrator per channel drives a
// hysteretic (MODE=1) or latching (MODE=0) output. SAMPLE advances every
// channel's integrator. Q, RISE and FALL are all registered.
module slib_hyst_filter #(
  parameter int unsigned CHANNELS = 4,
  parameter int unsigned WIDTH    = 4,
  parameter int unsigned SET_TH   = 10,
  parameter int unsigned CLR_TH   = 3,
  parameter int unsigned MODE     = 1
) (
  input  logic                CLK,
  input  logic                RST,
  input  logic                SAMPLE,
  input  logic [CHANNELS-1:0] CLEAR,
  input  logic [CHANNELS-1:0] D,
  output logic [CHANNELS-1:0] Q,
  output logic [CHANNELS-1:0] RISE,
  output logic [CHANNELS-1:0] FALL
);

  // Largest count a WIDTH-bit integrator can hold.
  localparam int unsigned MaxVal = (WIDTH >= 32) ? 32'hFFFF_FFFF
                                                 : ((32'd1 << WIDTH) - 32'd1);
  localparam logic [WIDTH-1:0] CntMax = {WIDTH{1'b1}};
  localparam logic [WIDTH-1:0] SetTh  = WIDTH'(SET_TH);
  localparam logic [WIDTH-1:0] ClrTh  = WIDTH'(CLR_TH);

  // Reject parameter sets whose thresholds the counter cannot represent.
  if (CHANNELS < 1) begin : g_bad_channels
    $error("slib_hyst_filter: CHANNELS must be >= 1");
  end
  if (WIDTH < 1) begin : g_bad_width
    $error("slib_hyst_filter: WIDTH must be >= 1");
  end
  if ((SET_TH < 1) || (SET_TH > MaxVal)) begin : g_bad_set_th
    $error("slib_hyst_filter: SET_TH must be in 1..2**WIDTH-1");
  end
  if ((MODE == 1) && (CLR_TH >= SET_TH)) begin : g_bad_clr_th
    $error("slib_hyst_filter: CLR_TH must be below SET_TH in MODE 1");
  end
  if (MODE > 1) begin : g_bad_mode
    $error("slib_hyst_filter: MODE must be 0 or 1");
  end

  logic [WIDTH-1:0]    cnt_q [CHANNELS];
  logic [WIDTH-1:0]    cnt_d [CHANNELS];
  logic [CHANNELS-1:0] q_q, q_d;
  logic [CHANNELS-1:0] rise_q, fall_q;

  // Per-channel integrator and output next-state; CLEAR overrides everything.
  always_comb begin
    for (int i = 0; i < CHANNELS; i++) begin
      cnt_d[i] = cnt_q[i];
      q_d[i]   = q_q[i];
      if (CLEAR[i]) begin
        cnt_d[i] = '0;
        q_d[i]   = 1'b0;
      end else begin
        if (SAMPLE) begin
          if (MODE == 1) begin
            if (D[i]) begin
              if (cnt_q[i] != CntMax) cnt_d[i] = cnt_q[i] + 1'b1;
            end else begin
              if (cnt_q[i] != '0) cnt_d[i] = cnt_q[i] - 1'b1;
            end
          end else begin
            // Latching mode only counts up and stops at the set threshold.
            if (D[i] && (cnt_q[i] < SetTh)) cnt_d[i] = cnt_q[i] + 1'b1;
          end
        end
        // Output decision looks at the current count, giving one cycle of lag.
        if (cnt_q[i] >= SetTh) begin
          q_d[i] = 1'b1;
        end else if ((MODE == 1) && (cnt_q[i] <= ClrTh)) begin
          q_d[i] = 1'b0;
        end
      end
    end
  end

  // State registers; edge pulses are registered alongside Q.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      cnt_q  <= '{default: '0};
      q_q    <= '0;
      rise_q <= '0;
      fall_q <= '0;
    end else begin
      cnt_q  <= cnt_d;
      q_q    <= q_d;
      rise_q <= ~q_q & q_d;
      fall_q <= q_q & ~q_d;
    end
  end

  assign Q    = q_q;
  assign RISE = rise_q;
  assign FALL = fall_q;

endmodule

// File: tb/tb_slib_hyst_filter.sv
// Directed bench for slib_hyst_filter: one MODE=1 instance and one MODE=0
// instance, defaults otherwise (4 channels, WIDTH 4, SET_TH 10, CLR_TH 3).
module tb_slib_hyst_filter;

  logic       CLK = 1'b0;
  logic       RST;
  logic       SAMPLE;
  logic [3:0] CLEAR, D, Q, RISE, FALL;
  logic       S0;
  logic [3:0] C0, D0, Q0, RISE0, FALL0;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 CLK = ~CLK;

  slib_hyst_filter #(
    .CHANNELS(4), .WIDTH(4), .SET_TH(10), .CLR_TH(3), .MODE(1)
  ) dut (
    .CLK    (CLK),
    .RST    (RST),
    .SAMPLE (SAMPLE),
    .CLEAR  (CLEAR),
    .D      (D),
    .Q      (Q),
    .RISE   (RISE),
    .FALL   (FALL)
  );

  slib_hyst_filter #(
    .CHANNELS(4), .WIDTH(4), .SET_TH(10), .CLR_TH(3), .MODE(0)
  ) dut0 (
    .CLK    (CLK),
    .RST    (RST),
    .SAMPLE (S0),
    .CLEAR  (C0),
    .D      (D0),
    .Q      (Q0),
    .RISE   (RISE0),
    .FALL   (FALL0)
  );

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    RST = 1'b1; SAMPLE = 1'b0; CLEAR = '0; D = '0;
    S0  = 1'b0; C0 = '0; D0 = '0;
    tick();
    tick();
    chk("reset_mode1", {Q, RISE, FALL}, 32'h0);
    chk("reset_mode0", {Q0, RISE0, FALL0}, 32'h0);
    RST = 1'b0;

    // T1: count up on channel 0, Q rises on edge 11.
    SAMPLE = 1'b1; D = 4'b0001;
    for (int k = 1; k <= 10; k++) begin
      tick();
      chk("t1_q_low", {Q, RISE}, 32'h0);
    end
    tick();
    chk("t1_q_rise", {Q, RISE, FALL}, {20'h0, 4'b0001, 4'b0001, 4'b0000});
    tick();
    chk("t1_rise_end", {Q, RISE, FALL}, {20'h0, 4'b0001, 4'b0000, 4'b0000});

    // T2: saturate at 15, then decay; Q clears on the 13th D=0 edge.
    for (int k = 13; k <= 17; k++) begin
      tick();
      chk("t2_sat_hold", {Q, RISE, FALL}, {20'h0, 4'b0001, 8'h00});
    end
    D = 4'b0000;
    for (int j = 1; j <= 12; j++) begin
      tick();
      chk("t2_decay_hold", {Q, FALL}, {24'h0, 4'b0001, 4'b0000});
    end
    tick();
    chk("t2_fall", {Q, RISE, FALL}, {20'h0, 4'b0000, 4'b0000, 4'b0001});
    tick();
    chk("t2_fall_end", {Q, RISE, FALL}, 32'h0);
    for (int j = 15; j <= 18; j++) begin
      tick();
      chk("t2_zero_sat", {Q, RISE, FALL}, 32'h0);
    end

    // T3: alternating samples never reach the threshold.
    for (int k = 0; k < 40; k++) begin
      D = (k % 2 == 0) ? 4'b0001 : 4'b0000;
      tick();
      chk("t3_glitch", {Q, RISE, FALL}, 32'h0);
    end

    // T5: CLEAR[1] on the edge where Q would set; other channels rise.
    D = 4'b1111;
    for (int k = 1; k <= 10; k++) begin
      tick();
      chk("t5_count", {Q, RISE}, 32'h0);
    end
    CLEAR = 4'b0010;
    tick();
    chk("t5_clear_win", {Q, RISE, FALL}, {20'h0, 4'b1101, 4'b1101, 4'b0000});
    CLEAR = 4'b0000;
    for (int k = 12; k <= 21; k++) begin
      tick();
      chk("t5_ch1_recount", {Q, RISE}, {24'h0, 4'b1101, 4'b0000});
    end
    tick();
    chk("t5_ch1_rise", {Q, RISE, FALL}, {20'h0, 4'b1111, 4'b0010, 4'b0000});

    // T6: ch2 decays to 7 with Q still set, then an asynchronous reset.
    D = 4'b1011;
    for (int k = 1; k <= 8; k++) begin
      tick();
      chk("t6_decay_hold", {Q, RISE, FALL}, {20'h0, 4'b1111, 8'h00});
    end
    #3 RST = 1'b1;
    #1 chk("t6_async_rst", {Q, RISE, FALL}, 32'h0);
    tick();
    chk("t6_in_rst", {Q, RISE, FALL}, 32'h0);
    RST = 1'b0; D = 4'b1111;
    for (int k = 1; k <= 10; k++) begin
      tick();
      chk("t6_recount", {Q, RISE}, 32'h0);
    end
    tick();
    chk("t6_rise", {Q, RISE, FALL}, {20'h0, 4'b1111, 4'b1111, 4'b0000});

    // T4: latching mode on the MODE=0 instance.
    SAMPLE = 1'b0; D = '0;
    S0 = 1'b1; D0 = 4'b0001;
    for (int k = 1; k <= 10; k++) begin
      tick();
      chk("t4_count", {Q0, RISE0}, 32'h0);
    end
    D0 = 4'b0000;
    tick();
    chk("t4_rise", {Q0, RISE0, FALL0}, {20'h0, 4'b0001, 4'b0001, 4'b0000});
    for (int k = 1; k <= 50; k++) begin
      tick();
      chk("t4_latched", {Q0, RISE0, FALL0}, {20'h0, 4'b0001, 8'h00});
    end
    C0 = 4'b0001;
    tick();
    chk("t4_clear_fall", {Q0, RISE0, FALL0}, {20'h0, 4'b0000, 4'b0000, 4'b0001});
    C0 = 4'b0000;
    tick();
    chk("t4_fall_end", {Q0, RISE0, FALL0}, 32'h0);
    D0 = 4'b0001;
    for (int k = 1; k <= 10; k++) begin
      tick();
      chk("t4_recount", {Q0, RISE0}, 32'h0);
    end
    tick();
    chk("t4_rerise", {Q0, RISE0, FALL0}, {20'h0, 4'b0001, 4'b0001, 4'b0000});

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
